// File: rtl/ftdnn_conv_pkg.sv
// rtl/ftdnn_conv_pkg.sv - shared types and default sizes for the convolution scheduler
//
// Holds the scheduler state encoding and the default array geometry:
// number of sub-block rows, temporal parameter width and half-word
// activation buffer width.

package ftdnn_conv_pkg;

    localparam int HW_D3             = 4;
    localparam int HW_TEMP_PARAM_LEN = 64;
    localparam int ACTBUF_DATA_LEN   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CFG    = 2'd1,
        STREAM = 2'd2,
        WAIT   = 2'd3
    } state_t;

endpackage

// File: rtl/ftdnn_conv_sched.sv
// rtl/ftdnn_conv_sched.sv - layer scheduler feeding the convolution array
//
// Accepts one layer descriptor at a time, broadcasts its temporal parameters,
// streams the layer's activation words into the activation buffers, then waits
// for all sub-block rows to go idle before reporting the layer done.
//
// Ports:
//   clk_l, rst_n                 low-speed clock, async active-low reset
//   desc_vld/desc_rdy            descriptor handshake
//   desc_param/words/last        layer parameters, word count, last-layer flag
//   act_in_data/vld/rdy          activation source stream
//   temp_param, temp_param_en    held parameters and one-cycle load strobe
//   actbuf_wr_data/vld           activation write to the array
//   actbuf_wr_req                array can accept a write on all rows
//   sblk_status                  per-row busy flags
//   busy, layer_idx              status
//   layer_done, net_done         one-cycle completion pulses

module ftdnn_conv_sched
    import ftdnn_conv_pkg::*;
#(
    parameter int PARAM_LEN = HW_TEMP_PARAM_LEN,
    parameter int D3        = HW_D3,
    parameter int ACT_W     = 2 * ACTBUF_DATA_LEN,
    parameter int CNT_W     = 16,
    parameter int SETTLE    = 2
) (
    input  logic                 clk_l,
    input  logic                 rst_n,
    input  logic                 desc_vld,
    output logic                 desc_rdy,
    input  logic [PARAM_LEN-1:0] desc_param,
    input  logic [CNT_W-1:0]     desc_words,
    input  logic                 desc_last,
    input  logic [ACT_W-1:0]     act_in_data,
    input  logic                 act_in_vld,
    output logic                 act_in_rdy,
    output logic [PARAM_LEN-1:0] temp_param,
    output logic                 temp_param_en,
    output logic [ACT_W-1:0]     actbuf_wr_data,
    output logic                 actbuf_wr_vld,
    input  logic                 actbuf_wr_req,
    input  logic [D3-1:0]        sblk_status,
    output logic                 busy,
    output logic [7:0]           layer_idx,
    output logic                 layer_done,
    output logic                 net_done
);

    localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

    state_t          state;
    state_t          state_nxt;
    logic [CNT_W-1:0] cnt;
    logic            last_q;
    logic [SW-1:0]   settle_cnt;
    logic            settle_done;
    logic            accept;
    logic            xfer;
    logic            done_now;

    // Row status is not trusted until the array has had SETTLE cycles to
    // reflect the last written word.
    assign settle_done = (settle_cnt == SW'(SETTLE));
    assign busy        = (state != IDLE);

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        desc_rdy       = 1'b0;
        act_in_rdy     = 1'b0;
        actbuf_wr_vld  = 1'b0;
        actbuf_wr_data = '0;
        temp_param_en  = 1'b0;
        accept         = 1'b0;
        xfer           = 1'b0;
        done_now       = 1'b0;
        case (state)
            IDLE: begin
                // Held low while reset is asserted even though state reads IDLE.
                desc_rdy = rst_n;
                if (desc_vld) begin
                    accept    = 1'b1;
                    state_nxt = CFG;
                end
            end
            CFG: begin
                temp_param_en = 1'b1;
                state_nxt     = (cnt != '0) ? STREAM : WAIT;
            end
            STREAM: begin
                act_in_rdy     = actbuf_wr_req;
                actbuf_wr_data = act_in_data;
                xfer           = act_in_vld & actbuf_wr_req;
                actbuf_wr_vld  = xfer;
                if (xfer && (cnt == CNT_W'(1))) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (settle_done && (sblk_status == '0)) begin
                    done_now  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            last_q     <= 1'b0;
            temp_param <= '0;
            settle_cnt <= '0;
            layer_done <= 1'b0;
            net_done   <= 1'b0;
            layer_idx  <= 8'd0;
        end else begin
            layer_done <= done_now;
            net_done   <= done_now & last_q;

            if (accept) begin
                cnt        <= desc_words;
                last_q     <= desc_last;
                temp_param <= desc_param;
            end else if (xfer) begin
                // STREAM is only entered with cnt non-zero and left on cnt==1.
                cnt <= cnt - 1'b1;
            end

            if (state != WAIT) begin
                settle_cnt <= '0;
            end else if (!settle_done) begin
                settle_cnt <= settle_cnt + 1'b1;
            end

            if (done_now) begin
                layer_idx <= last_q ? 8'd0 : layer_idx + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ftdnn_conv_sched.sv
// tb/tb_ftdnn_conv_sched.sv - self-checking bench for ftdnn_conv_sched

module tb_ftdnn_conv_sched;

    localparam int PARAM_LEN = 64;
    localparam int D3        = 4;
    localparam int ACT_W     = 32;
    localparam int CNT_W     = 16;
    localparam int SETTLE    = 2;

    logic                 clk_l = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 desc_vld;
    logic                 desc_rdy;
    logic [PARAM_LEN-1:0] desc_param;
    logic [CNT_W-1:0]     desc_words;
    logic                 desc_last;
    logic [ACT_W-1:0]     act_in_data;
    logic                 act_in_vld;
    logic                 act_in_rdy;
    logic [PARAM_LEN-1:0] temp_param;
    logic                 temp_param_en;
    logic [ACT_W-1:0]     actbuf_wr_data;
    logic                 actbuf_wr_vld;
    logic                 actbuf_wr_req;
    logic [D3-1:0]        sblk_status;
    logic                 busy;
    logic [7:0]           layer_idx;
    logic                 layer_done;
    logic                 net_done;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_idx  = 8'd0;

    always #5 clk_l = ~clk_l;

    ftdnn_conv_sched #(
        .PARAM_LEN(PARAM_LEN), .D3(D3), .ACT_W(ACT_W), .CNT_W(CNT_W), .SETTLE(SETTLE)
    ) dut (
        .clk_l(clk_l), .rst_n(rst_n),
        .desc_vld(desc_vld), .desc_rdy(desc_rdy), .desc_param(desc_param),
        .desc_words(desc_words), .desc_last(desc_last),
        .act_in_data(act_in_data), .act_in_vld(act_in_vld), .act_in_rdy(act_in_rdy),
        .temp_param(temp_param), .temp_param_en(temp_param_en),
        .actbuf_wr_data(actbuf_wr_data), .actbuf_wr_vld(actbuf_wr_vld),
        .actbuf_wr_req(actbuf_wr_req), .sblk_status(sblk_status),
        .busy(busy), .layer_idx(layer_idx), .layer_done(layer_done), .net_done(net_done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_desc_rdy"}, desc_rdy, 0);
        chk({tag, "_act_in_rdy"}, act_in_rdy, 0);
        chk({tag, "_wr_vld"}, actbuf_wr_vld, 0);
        chk({tag, "_wr_data"}, actbuf_wr_data, 0);
        chk({tag, "_temp_param"}, temp_param, 0);
        chk({tag, "_temp_param_en"}, temp_param_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_layer_idx"}, layer_idx, 0);
        chk({tag, "_layer_done"}, layer_done, 0);
        chk({tag, "_net_done"}, net_done, 0);
    endtask

    // Runs one layer starting in the current (IDLE) cycle, called just after a
    // negedge. Expected timing follows from the accept cycle (c=0): parameters
    // and strobe at c=1, streaming from c=2, WAIT from the cycle after the last
    // transfer, status sampled SETTLE cycles into WAIT, done one cycle after the
    // first all-zero sample. Returns in the layer_done cycle.
    // req_mode: 0 always ready, 1 toggling 1,0,1,..., 2 random.
    // busy_len: rows stay busy this many cycles into WAIT (mask 0 = random rows).
    task automatic run_layer(input logic [63:0] p, input int words, input bit last,
                             input int req_mode, input int vld_mode,
                             input int busy_len, input logic [3:0] mask);
        int         c;
        int         sent;
        int         seen;
        int         ws;
        int         d_cyc;
        bit         sdone;
        bit         in_stream;
        bit         req;
        bit         vld;
        bit         xfer;
        logic [7:0] nidx;
        logic [31:0] cur;

        desc_vld   = 1'b1;
        desc_param = p;
        desc_words = CNT_W'(words);
        desc_last  = last;
        #1;
        chk("desc_rdy_offer", desc_rdy, 1);
        chk("idx_start", layer_idx, exp_idx);

        nidx  = last ? 8'd0 : exp_idx + 8'd1;
        sent  = 0;
        seen  = 0;
        sdone = (words == 0);
        ws    = 2;
        d_cyc = sdone ? ws + ((SETTLE > busy_len) ? SETTLE : busy_len) + 1 : -1;
        c     = 0;

        while (1) begin
            @(negedge clk_l);
            c++;
            in_stream = (c >= 2) && (sent < words);
            case (req_mode)
                0:       req = 1'b1;
                1:       req = (c < 2) ? 1'b1 : (((c - 2) % 2) == 0);
                default: req = ($urandom_range(0, 2) != 0);
            endcase
            vld = (vld_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            cur = $urandom;

            // A competing descriptor is offered at random during the layer and
            // must be held off; it is withdrawn in the done cycle.
            desc_vld      = (c == d_cyc) ? 1'b0 : 1'($urandom_range(0, 1));
            desc_param    = {$urandom, $urandom};
            desc_words    = CNT_W'($urandom_range(0, 9));
            desc_last     = 1'($urandom_range(0, 1));
            act_in_data   = cur;
            act_in_vld    = vld;
            actbuf_wr_req = req;
            if (!sdone || (c < ws + busy_len))
                sblk_status = (mask != 0) ? mask : 4'($urandom_range(1, 15));
            else
                sblk_status = '0;

            xfer = in_stream && vld && req;
            #1;
            chk("temp_param_en", temp_param_en, (c == 1));
            chk("temp_param", temp_param, p);
            chk("act_in_rdy", act_in_rdy, in_stream && req);
            chk("wr_vld", actbuf_wr_vld, xfer);
            if (xfer) chk("wr_data", actbuf_wr_data, cur);
            chk("layer_done", layer_done, (c == d_cyc));
            chk("net_done", net_done, (c == d_cyc) && last);
            chk("desc_rdy", desc_rdy, (c == d_cyc));
            chk("busy", busy, (c != d_cyc));
            chk("layer_idx", layer_idx, (c == d_cyc) ? nidx : exp_idx);
            if (actbuf_wr_vld === 1'b1) seen++;

            if (xfer) begin
                sent++;
                if (sent == words) begin
                    sdone = 1'b1;
                    ws    = c + 1;
                    d_cyc = ws + ((SETTLE > busy_len) ? SETTLE : busy_len) + 1;
                end
            end
            if (c == d_cyc) break;
            if (c > 600) begin
                chk("layer_timeout", 0, 1);
                break;
            end
        end
        chk("xfer_count", seen, words);
        exp_idx = nidx;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        desc_vld      = 1'b0;
        desc_param    = '0;
        desc_words    = '0;
        desc_last     = 1'b0;
        act_in_data   = '0;
        act_in_vld    = 1'b0;
        actbuf_wr_req = 1'b0;
        sblk_status   = '0;

        repeat (3) @(negedge clk_l);
        desc_vld = 1'b1;
        #1;
        chk_all_zero("reset");
        desc_vld = 1'b0;
        @(negedge clk_l);
        rst_n = 1'b1;
        #1;
        chk("post_reset_desc_rdy", desc_rdy, 1);
        chk("post_reset_busy", busy, 0);

        // Single layer, free-flowing stream, last layer of a network.
        run_layer(64'hA5, 4, 1'b1, 0, 0, 0, 4'b0000);
        // Zero-word layer.
        run_layer({$urandom, $urandom}, 0, 1'b0, 0, 0, 0, 4'b0000);
        // Backpressure with toggling write request.
        run_layer({$urandom, $urandom}, 3, 1'b1, 1, 0, 0, 4'b0000);
        // Row 2 stays busy well past the settle window.
        run_layer({$urandom, $urandom}, 4, 1'b1, 0, 0, 10, 4'b0100);
        // Three-layer network, back to back.
        run_layer({$urandom, $urandom}, 2, 1'b0, 2, 1, 1, 4'b0000);
        run_layer({$urandom, $urandom}, 5, 1'b0, 2, 1, 3, 4'b0000);
        run_layer({$urandom, $urandom}, 1, 1'b1, 2, 1, 0, 4'b0000);
        chk("idx_after_net", layer_idx, 0);
        run_layer({$urandom, $urandom}, 2, 1'b0, 0, 0, 0, 4'b0000);

        // Reset in the middle of a 5-word stream after two transfers.
        desc_vld   = 1'b1;
        desc_param = 64'h1234_5678_9ABC_DEF0;
        desc_words = CNT_W'(5);
        desc_last  = 1'b0;
        @(negedge clk_l);
        desc_vld      = 1'b0;
        act_in_vld    = 1'b1;
        actbuf_wr_req = 1'b1;
        sblk_status   = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_l);
            #1;
            chk("rst_pre_wr_vld", actbuf_wr_vld, 1);
        end
        @(negedge clk_l);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk_l);
        rst_n         = 1'b1;
        act_in_vld    = 1'b0;
        actbuf_wr_req = 1'b0;
        exp_idx       = 8'd0;
        #1;
        chk("after_mid_reset_rdy", desc_rdy, 1);
        run_layer({$urandom, $urandom}, 5, 1'b0, 0, 0, 0, 4'b0000);

        // Randomized layers.
        for (int n = 0; n < 30; n++) begin
            run_layer({$urandom, $urandom}, $urandom_range(0, 10),
                      1'($urandom_range(0, 4) == 0), $urandom_range(0, 2),
                      $urandom_range(0, 1), $urandom_range(0, 8), 4'b0000);
        end

        // Enough short non-last layers to wrap the layer index past 255.
        for (int n = 0; n < 260; n++) begin
            run_layer({$urandom, $urandom}, $urandom_range(0, 1), 1'b0, 0, 0, 0, 4'b0000);
        end

        desc_vld = 1'b0;
        @(negedge clk_l);
        #1;
        chk("final_idle_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
